// File: rtl/bcd_display_loader_if.sv
// bcd_display_loader_if: start/value request plus display-core write port
interface bcd_display_loader_if #(
  parameter int BIN_W = 27,
  parameter int DIGITS = 8,
  parameter int SEL_W = $clog2(DIGITS)
);
  logic start;
  logic [BIN_W-1:0] bin_in;
  logic busy;
  logic done;
  logic ovf;
  logic [SEL_W-1:0] sel;
  logic [3:0] num;
  logic write;
  modport master (output start, bin_in, input busy, done, ovf, sel, num, write);
  modport slave (input start, bin_in, output busy, done, ovf, sel, num, write);
endinterface

// File: rtl/bcd_display_loader.sv
// bcd_display_loader: binary to BCD by double dabble, then one digit write per cycle
module bcd_display_loader #(
  parameter int BIN_W = 27,
  parameter int DIGITS = 8
) (
  input logic clk,
  input logic reset,
  bcd_display_loader_if.slave bus
);
  localparam int SEL_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(BIN_W);
  localparam int BCD_W = 4 * DIGITS;

  function automatic longint unsigned max_val();
    longint unsigned p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint unsigned MAX = max_val();

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

  state_t state, state_d;
  logic [BIN_W-1:0] shift, shift_d;
  logic [BCD_W-1:0] bcd, bcd_d, adj;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] idx, idx_d, sel, sel_d;
  logic [3:0] num, num_d;
  logic ovf, ovf_d, busy, busy_d, done, done_d, write, write_d;

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.ovf = ovf;
  assign bus.sel = sel;
  assign bus.num = num;
  assign bus.write = write;

  // Register state, datapath and all outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      bcd <= '0;
      cnt <= '0;
      idx <= '0;
      sel <= '0;
      num <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      write <= 1'b0;
    end else begin
      state <= state_d;
      shift <= shift_d;
      bcd <= bcd_d;
      cnt <= cnt_d;
      idx <= idx_d;
      sel <= sel_d;
      num <= num_d;
      ovf <= ovf_d;
      busy <= busy_d;
      done <= done_d;
      write <= write_d;
    end
  end

  // Next state and next register values; nibbles >=5 get +3 before each shift
  always_comb begin
    state_d = state;
    shift_d = shift;
    bcd_d = bcd;
    cnt_d = cnt;
    idx_d = idx;
    sel_d = sel;
    num_d = num;
    ovf_d = ovf;
    busy_d = busy;
    done_d = 1'b0;
    write_d = 1'b0;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    case (state)
      IDLE: if (bus.start) begin
        state_d = CONVERT;
        shift_d = bus.bin_in;
        bcd_d = '0;
        cnt_d = '0;
        ovf_d = 64'(bus.bin_in) > MAX;
        busy_d = 1'b1;
      end
      CONVERT: begin
        {bcd_d, shift_d} = {adj, shift} << 1;
        cnt_d = cnt + 1'b1;
        idx_d = '0;
        state_d = cnt == CNT_W'(BIN_W - 1) ? WRITE : CONVERT;
      end
      WRITE: begin
        write_d = 1'b1;
        sel_d = idx;
        num_d = ovf ? 4'hF : bcd[{idx, 2'b00} +: 4];
        idx_d = idx + 1'b1;
        state_d = idx == SEL_W'(DIGITS - 1) ? DONE : WRITE;
      end
      default: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_bcd_display_loader.sv
// tb_bcd_display_loader: directed vectors and corner sequences for bcd_display_loader
module tb_bcd_display_loader;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  bcd_display_loader_if #(.BIN_W(27), .DIGITS(8)) b ();
  bcd_display_loader #(.BIN_W(27), .DIGITS(8)) dut (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] exp;
    logic ovf;
    int pulse;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask

  // One conversion: start accepted at edge k, cycle c sampled #1 after edge k+c
  task automatic run(input logic [26:0] v, input logic [31:0] exp, input logic e_ovf, input int pulse);
    int nw, first, dc, dcyc;
    logic [31:0] got;
    nw = 0; first = -1; dc = 0; dcyc = -1; got = '0;
    @(negedge clk);
    b.start = 1'b1;
    b.bin_in = v;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    b.bin_in = ~v;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk("busy_after_start", 64'(b.busy), 64'd1);
      if (b.write) begin
        if (first < 0) first = c;
        chk("sel_order", 64'(b.sel), 64'(nw[2:0]));
        got[{b.sel, 2'b00} +: 4] = b.num;
        nw++;
      end
      if (b.done) begin
        dc++;
        dcyc = c;
      end
      b.start = c == pulse;
      b.bin_in = c == pulse ? 27'd5 : ~v;
    end
    b.start = 1'b0;
    chk("first_write_cycle", 64'(first), 64'd28);
    chk("write_count", 64'(nw), 64'd8);
    chk("done_count", 64'(dc), 64'd1);
    chk("done_cycle", 64'(dcyc), 64'd36);
    chk("digits", 64'(got), 64'(exp));
    chk("ovf", 64'(b.ovf), 64'(e_ovf));
    chk("idle_busy", 64'(b.busy), 64'd0);
  endtask

  // Start a conversion, pull reset at cycle 'at', then confirm nothing else happens
  task automatic abort(input int at);
    int nw;
    nw = 0;
    @(negedge clk);
    b.start = 1'b1;
    b.bin_in = 27'd12345678;
    @(posedge clk);
    #1;
    b.start = 1'b0;
    repeat (at) @(posedge clk);
    #1;
    chk("pre_reset_write", 64'(b.write), 64'(at >= 28));
    reset = 1'b0;
    #1;
    chk("reset_write", 64'(b.write), 64'd0);
    chk("reset_busy", 64'(b.busy), 64'd0);
    chk("reset_sel", 64'(b.sel), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (b.write || b.busy || b.done) nw++;
    end
    chk("post_reset_activity", 64'(nw), 64'd0);
  endtask

  initial begin
    int dc, nw;
    reset = 1'b0;
    b.start = 1'b0;
    b.bin_in = '0;
    vecs[0] = '{27'd12345678, 32'h12345678, 1'b0, 0};
    vecs[1] = '{27'd0, 32'h00000000, 1'b0, 0};
    vecs[2] = '{27'd99999999, 32'h99999999, 1'b0, 0};
    vecs[3] = '{27'd100000000, 32'hFFFFFFFF, 1'b1, 0};
    vecs[4] = '{27'd7, 32'h00000007, 1'b0, 0};
    vecs[5] = '{27'd134217727, 32'hFFFFFFFF, 1'b1, 5};
    vecs[6] = '{27'd10000000, 32'h10000000, 1'b0, 30};
    vecs[7] = '{27'd87654321, 32'h87654321, 1'b0, 35};
    vecs[8] = '{27'd90909090, 32'h90909090, 1'b0, 5};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(b.busy), 64'd0);
    chk("rst_done", 64'(b.done), 64'd0);
    chk("rst_ovf", 64'(b.ovf), 64'd0);
    chk("rst_write", 64'(b.write), 64'd0);
    chk("rst_sel", 64'(b.sel), 64'd0);
    chk("rst_num", 64'(b.num), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) run(vecs[i].bin, vecs[i].exp, vecs[i].ovf, vecs[i].pulse);
    // start held high: second conversion accepted the cycle after DONE
    dc = 0;
    nw = 0;
    @(negedge clk);
    b.start = 1'b1;
    b.bin_in = 27'd12345678;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (c == 36) chk("b2b_busy_done", 64'(b.busy), 64'd0);
      if (c == 37) chk("b2b_busy_restart", 64'(b.busy), 64'd1);
      if (c == 64) chk("b2b_no_early_write", 64'(b.write), 64'd0);
      if (c == 65) chk("b2b_second_write", 64'(b.write), 64'd1);
      if (b.done) dc++;
      if (b.write) nw++;
      if (c == 37) b.start = 1'b0;
    end
    chk("b2b_done_count", 64'(dc), 64'd2);
    chk("b2b_write_count", 64'(nw), 64'd16);
    abort(10);
    abort(30);
    run(27'd42, 32'h00000042, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
